// File: rtl/bcd_serial_sequencer_pkg.sv
// Shared types and constants for the serial BCD adder/subtractor.
// The state encoding is fixed so it can be probed from the display path.
package bcd_serial_sequencer_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StLoad = 2'd1,
      StAdd  = 2'd2,
      StDone = 2'd3
   } state_e;

   localparam logic [3:0] BCD_MAX = 4'd9;

   function automatic logic [3:0] nines_comp(input logic [3:0] d);
      return BCD_MAX - d;
   endfunction

endpackage

// File: rtl/bcd_serial_sequencer_digit_slice.sv
// Combinational single-digit BCD adder with +6 decimal correction.
module bcd_digit_slice (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       cin_i,
   output logic [3:0] sum_o,
   output logic       cout_o
);

   logic [4:0] raw;

   always_comb begin
      raw    = {1'b0, a_i} + {1'b0, b_i} + {4'b0, cin_i};
      cout_o = (raw > 5'd9);
      sum_o  = cout_o ? 4'(raw + 5'd6) : raw[3:0];
   end

endmodule

// File: rtl/bcd_serial_sequencer.sv
// Serial multi-digit BCD adder/subtractor: one digit slice reused LSD first,
// with a one-cycle done pulse and a held result.
module bcd_serial_sequencer
   import bcd_serial_sequencer_pkg::*;
#(
   parameter int unsigned DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  sub,
   input  logic [4*DIGITS-1:0]   a,
   input  logic [4*DIGITS-1:0]   b,
   output logic                  ready,
   output logic                  done,
   output logic [4*DIGITS-1:0]   sum,
   output logic                  cout,
   output logic                  invalid
);

   localparam int unsigned W = 4 * DIGITS;

   state_e       state_q, state_d;
   logic [W-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic [2:0]   idx_q, idx_d;
   logic         sub_q, sub_d, carry_q, carry_d;
   logic         cout_q, cout_d, invalid_q, invalid_d;
   logic         done_q, done_d, ready_q, ready_d;

   logic [3:0]   dig_a, dig_b_raw, dig_b, slice_sum;
   logic         slice_cout, any_bad;

   always_comb begin
      dig_a     = '0;
      dig_b_raw = '0;
      any_bad   = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_q == 3'(i)) begin
            dig_a     = a_q[4*i +: 4];
            dig_b_raw = b_q[4*i +: 4];
         end
         if (a_q[4*i +: 4] > BCD_MAX || b_q[4*i +: 4] > BCD_MAX) begin
            any_bad = 1'b1;
         end
      end
      dig_b = sub_q ? nines_comp(dig_b_raw) : dig_b_raw;
   end

   bcd_digit_slice u_slice (
      .a_i    (dig_a),
      .b_i    (dig_b),
      .cin_i  (carry_q),
      .sum_o  (slice_sum),
      .cout_o (slice_cout)
   );

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      sub_d     = sub_q;
      sum_d     = sum_q;
      idx_d     = idx_q;
      carry_d   = carry_q;
      cout_d    = cout_q;
      invalid_d = invalid_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               sub_d   = sub;
               state_d = StLoad;
            end
         end
         StLoad: begin
            sum_d     = '0;
            cout_d    = 1'b0;
            invalid_d = 1'b0;
            if (any_bad) begin
               invalid_d = 1'b1;
               state_d   = StDone;
            end else begin
               idx_d   = '0;
               carry_d = sub_q;  // subtraction = A + nines(B) + 1
               state_d = StAdd;
            end
         end
         StAdd: begin
            for (int i = 0; i < DIGITS; i++) begin
               if (idx_q == 3'(i)) sum_d[4*i +: 4] = slice_sum;
            end
            carry_d = slice_cout;
            if (idx_q == 3'(DIGITS - 1)) begin
               cout_d  = slice_cout;
               state_d = StDone;
            end else begin
               idx_d = idx_q + 3'd1;
            end
         end
         StDone: state_d = StIdle;
      endcase
      // Outputs are registered against the state being entered
      done_d  = (state_d == StDone);
      ready_d = (state_d == StIdle);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         a_q       <= '0;
         b_q       <= '0;
         sub_q     <= 1'b0;
         sum_q     <= '0;
         idx_q     <= '0;
         carry_q   <= 1'b0;
         cout_q    <= 1'b0;
         invalid_q <= 1'b0;
         done_q    <= 1'b0;
         ready_q   <= 1'b1;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         sub_q     <= sub_d;
         sum_q     <= sum_d;
         idx_q     <= idx_d;
         carry_q   <= carry_d;
         cout_q    <= cout_d;
         invalid_q <= invalid_d;
         done_q    <= done_d;
         ready_q   <= ready_d;
      end
   end

   assign ready   = ready_q;
   assign done    = done_q;
   assign sum     = sum_q;
   assign cout    = cout_q;
   assign invalid = invalid_q;

endmodule

// File: tb/tb_bcd_serial_sequencer.sv
// Directed self-checking bench for bcd_serial_sequencer with DIGITS=4.
module tb_bcd_serial_sequencer;

   localparam int unsigned D = 4;

   logic          clk = 1'b0;
   logic          rst, start, sub;
   logic [4*D-1:0] a, b, sum;
   logic          ready, done, cout, invalid;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   bcd_serial_sequencer #(.DIGITS(D)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .sub     (sub),
      .a       (a),
      .b       (b),
      .ready   (ready),
      .done    (done),
      .sum     (sum),
      .cout    (cout),
      .invalid (invalid)
   );

   // Waits for ready, issues one start, returns edges from acceptance to done (-1 on timeout).
   task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input logic isub,
                         input bit poke, output int lat, output int waited);
      waited = 0;
      while (!ready && waited < 50) begin
         @(posedge clk); #1;
         waited++;
      end
      a = ia; b = ib; sub = isub; start = 1'b1;
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (k == 1) begin
            start = 1'b0;
            a = 16'hFFFF; b = 16'hFFFF; sub = ~isub;
            if (poke) start = 1'b1;
         end
         if (k == 2) start = 1'b0;
         if (done) begin
            lat = k;
            break;
         end
      end
      start = 1'b0;
   endtask

   task automatic check_result(input string name, input int lat, input int exp_lat,
                               input logic [15:0] exp_sum, input logic exp_cout,
                               input logic exp_inv);
      checks++;
      if (lat !== exp_lat) begin
         failures++;
         $display("FAIL %s latency got=%0d want=%0d", name, lat, exp_lat);
      end
      checks++;
      if (sum !== exp_sum) begin
         failures++;
         $display("FAIL %s sum got=%h want=%h", name, sum, exp_sum);
      end
      checks++;
      if (cout !== exp_cout) begin
         failures++;
         $display("FAIL %s cout got=%b want=%b", name, cout, exp_cout);
      end
      checks++;
      if (invalid !== exp_inv) begin
         failures++;
         $display("FAIL %s invalid got=%b want=%b", name, invalid, exp_inv);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; sub = 1'b0; a = 16'h1111; b = 16'h2222;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (ready !== 1'b1 || done !== 1'b0) begin
         failures++;
         $display("FAIL reset ready/done got=%b/%b want=1/0", ready, done);
      end
      checks++;
      if (sum !== 16'h0000 || cout !== 1'b0 || invalid !== 1'b0) begin
         failures++;
         $display("FAIL reset sum/cout/invalid got=%h/%b/%b want=0000/0/0", sum, cout, invalid);
      end
      start = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_dominates_start ready got=%b want=1", ready);
      end
   endtask

   task automatic test_add();
      int lat, w;
      run_op(16'h1234, 16'h5678, 1'b0, 1'b0, lat, w);
      check_result("add_1234_5678", lat, 6, 16'h6912, 1'b0, 1'b0);
      checks++;
      if (ready !== 1'b0) begin
         failures++;
         $display("FAIL add_ready_in_done got=%b want=0", ready);
      end
      @(posedge clk); #1;
      checks++;
      if (ready !== 1'b1 || done !== 1'b0 || sum !== 16'h6912) begin
         failures++;
         $display("FAIL add_after_done ready/done/sum got=%b/%b/%h want=1/0/6912",
                  ready, done, sum);
      end
   endtask

   task automatic test_carry_ripple();
      int lat, w;
      run_op(16'h9999, 16'h0001, 1'b0, 1'b0, lat, w);
      check_result("ripple_9999_0001", lat, 6, 16'h0000, 1'b1, 1'b0);
   endtask

   task automatic test_sub();
      int lat, w;
      run_op(16'h5000, 16'h1234, 1'b1, 1'b0, lat, w);
      check_result("sub_5000_1234", lat, 6, 16'h3766, 1'b1, 1'b0);
      run_op(16'h1234, 16'h5000, 1'b1, 1'b0, lat, w);
      check_result("sub_1234_5000", lat, 6, 16'h6234, 1'b0, 1'b0);
   endtask

   task automatic test_invalid();
      int lat, w, extra;
      run_op(16'h12A4, 16'h0000, 1'b0, 1'b1, lat, w);
      check_result("invalid_12A4", lat, 2, 16'h0000, 1'b0, 1'b1);
      extra = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (done) extra++;
      end
      checks++;
      if (extra !== 0) begin
         failures++;
         $display("FAIL busy_start_ignored extra_done got=%0d want=0", extra);
      end
      checks++;
      if (invalid !== 1'b1) begin
         failures++;
         $display("FAIL invalid_held got=%b want=1", invalid);
      end
   endtask

   task automatic test_reset_mid();
      int lat, w, extra;
      a = 16'h1234; b = 16'h5678; sub = 1'b0; start = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk); #1;
         start = 1'b0;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if (ready !== 1'b1 || done !== 1'b0 || sum !== 16'h0000 || cout !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid ready/done/sum/cout got=%b/%b/%h/%b want=1/0/0000/0",
                  ready, done, sum, cout);
      end
      extra = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (done) extra++;
      end
      checks++;
      if (extra !== 0) begin
         failures++;
         $display("FAIL reset_mid_no_done got=%0d want=0", extra);
      end
      run_op(16'h0005, 16'h0005, 1'b0, 1'b0, lat, w);
      check_result("after_reset_0005_0005", lat, 6, 16'h0010, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      int lat, w;
      run_op(16'h0001, 16'h0002, 1'b0, 1'b0, lat, w);
      check_result("b2b_first", lat, 6, 16'h0003, 1'b0, 1'b0);
      run_op(16'h0999, 16'h0001, 1'b0, 1'b0, lat, w);
      checks++;
      if (w !== 1) begin
         failures++;
         $display("FAIL b2b_ready_wait got=%0d want=1", w);
      end
      check_result("b2b_second", lat, 6, 16'h1000, 1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
      test_reset();
      test_add();
      test_carry_ripple();
      test_sub();
      test_invalid();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
